// File: rtl/instr_seq.sv
// rtl/instr_seq.sv - instruction register, fetch/execute state bit, flags and one-hot opcode decoder
module instr_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ram_dout,
  input  logic       ir_ld,
  input  logic       sm_en,
  input  logic       cf_en,
  input  logic       zf_en,
  input  logic       c_in,
  input  logic       z_in,
  output logic [7:0] ir,
  output logic       sm,
  output logic       c,
  output logic       z,
  output logic       mova,
  output logic       movb,
  output logic       movc,
  output logic       add,
  output logic       sub,
  output logic       and1,
  output logic       not1,
  output logic       rsr,
  output logic       rsl,
  output logic       jmp,
  output logic       jz,
  output logic       jc,
  output logic       in1,
  output logic       out1,
  output logic       nop,
  output logic       halt
);

  typedef enum logic {
    FETCH   = 1'b0,
    EXECUTE = 1'b1
  } state_t;

  state_t state;

  // Halt is handled upstream: the generator withholds sm_en, so state simply holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      ir    <= 8'h00;
      c     <= 1'b0;
      z     <= 1'b0;
    end else begin
      if (ir_ld) ir <= ram_dout;
      if (sm_en) state <= (state == FETCH) ? EXECUTE : FETCH;
      if (cf_en) c <= c_in;
      if (zf_en) z <= z_in;
    end
  end

  assign sm = (state == EXECUTE);

  always_comb begin
    mova = 1'b0;
    movb = 1'b0;
    movc = 1'b0;
    add  = 1'b0;
    sub  = 1'b0;
    and1 = 1'b0;
    not1 = 1'b0;
    rsr  = 1'b0;
    rsl  = 1'b0;
    jmp  = 1'b0;
    jz   = 1'b0;
    jc   = 1'b0;
    in1  = 1'b0;
    out1 = 1'b0;
    nop  = 1'b0;
    halt = 1'b0;
    if (sm) begin
      case (ir[7:4])
        4'b1100: begin
          // Store form wins over load form, so 8'hCF decodes as movb only.
          if (ir[3:2] == 2'b11)      movb = 1'b1;
          else if (ir[1:0] == 2'b11) movc = 1'b1;
          else                       mova = 1'b1;
        end
        4'b1001: add  = 1'b1;
        4'b0110: sub  = 1'b1;
        4'b1011: and1 = 1'b1;
        4'b0101: not1 = 1'b1;
        4'b1010: begin
          rsr = (ir[1:0] == 2'b00);
          rsl = (ir[1:0] == 2'b11);
        end
        4'b0011: begin
          jmp = (ir[3:2] == 2'b00);
          jz  = (ir[3:2] == 2'b01);
          jc  = (ir[3:2] == 2'b10);
        end
        4'b0010: in1  = 1'b1;
        4'b0100: out1 = 1'b1;
        4'b0111: nop  = 1'b1;
        4'b1000: halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_seq.sv
// tb/tb_instr_seq.sv - self-checking bench for instr_seq: decode vector table, flag and halt sequences, random run against a reference model
module tb_instr_seq;

  logic       clk;
  logic       rst;
  logic [7:0] ram_dout;
  logic       ir_ld, sm_en, cf_en, zf_en, c_in, z_in;
  logic [7:0] ir;
  logic       sm, c, z;
  logic       mova, movb, movc, add, sub, and1, not1, rsr, rsl;
  logic       jmp, jz, jc, in1, out1, nop, halt;
  logic [15:0] lines;

  instr_seq dut (
    .clk(clk), .rst(rst), .ram_dout(ram_dout), .ir_ld(ir_ld), .sm_en(sm_en),
    .cf_en(cf_en), .zf_en(zf_en), .c_in(c_in), .z_in(z_in),
    .ir(ir), .sm(sm), .c(c), .z(z),
    .mova(mova), .movb(movb), .movc(movc), .add(add), .sub(sub), .and1(and1),
    .not1(not1), .rsr(rsr), .rsl(rsl), .jmp(jmp), .jz(jz), .jc(jc),
    .in1(in1), .out1(out1), .nop(nop), .halt(halt)
  );

  assign lines = {mova, movb, movc, add, sub, and1, not1, rsr, rsl,
                  jmp, jz, jc, in1, out1, nop, halt};

  localparam logic [15:0] L_NONE = 16'h0000;
  localparam logic [15:0] L_MOVA = 16'h8000;
  localparam logic [15:0] L_MOVB = 16'h4000;
  localparam logic [15:0] L_MOVC = 16'h2000;
  localparam logic [15:0] L_ADD  = 16'h1000;
  localparam logic [15:0] L_SUB  = 16'h0800;
  localparam logic [15:0] L_AND  = 16'h0400;
  localparam logic [15:0] L_NOT  = 16'h0200;
  localparam logic [15:0] L_RSR  = 16'h0100;
  localparam logic [15:0] L_RSL  = 16'h0080;
  localparam logic [15:0] L_JMP  = 16'h0040;
  localparam logic [15:0] L_JZ   = 16'h0020;
  localparam logic [15:0] L_JC   = 16'h0010;
  localparam logic [15:0] L_IN   = 16'h0008;
  localparam logic [15:0] L_OUT  = 16'h0004;
  localparam logic [15:0] L_NOP  = 16'h0002;
  localparam logic [15:0] L_HALT = 16'h0001;

  typedef struct {
    logic [7:0]  instr;
    logic [15:0] exp_lines;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state and a byte-indexed decode table built from the opcode rules.
  logic [7:0]  m_ir;
  logic        m_sm, m_c, m_z;
  logic [15:0] dec_tab [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_lines(input logic [7:0] r, input logic s);
    return s ? dec_tab[r] : 16'h0000;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".ir"}, {8'h00, ir}, {8'h00, m_ir});
    chk({tag, ".sm"}, {15'h0, sm}, {15'h0, m_sm});
    chk({tag, ".c"}, {15'h0, c}, {15'h0, m_c});
    chk({tag, ".z"}, {15'h0, z}, {15'h0, m_z});
    chk({tag, ".lines"}, lines, model_lines(m_ir, m_sm));
  endtask

  task automatic step(input logic [7:0] rd, input logic ld, input logic se,
                      input logic ce, input logic ze, input logic ci, input logic zi);
    ram_dout = rd; ir_ld = ld; sm_en = se;
    cf_en = ce; zf_en = ze; c_in = ci; z_in = zi;
    @(posedge clk);
    #1;
    if (ld) m_ir = rd;
    if (se) m_sm = ~m_sm;
    if (ce) m_c = ci;
    if (ze) m_z = zi;
  endtask

  task automatic model_reset();
    m_ir = 8'h00; m_sm = 1'b0; m_c = 1'b0; m_z = 1'b0;
  endtask

  vec_t vecs [25];

  initial begin
    for (int b = 0; b < 256; b++) begin
      int op, lo, mid;
      logic [15:0] v;
      op = b / 16; mid = (b / 4) % 4; lo = b % 4;
      v = L_NONE;
      if (op == 12) v = (mid == 3) ? L_MOVB : ((lo == 3) ? L_MOVC : L_MOVA);
      else if (op == 9)  v = L_ADD;
      else if (op == 6)  v = L_SUB;
      else if (op == 11) v = L_AND;
      else if (op == 5)  v = L_NOT;
      else if (op == 10) v = (lo == 0) ? L_RSR : ((lo == 3) ? L_RSL : L_NONE);
      else if (op == 3)  v = (mid == 0) ? L_JMP : (mid == 1) ? L_JZ : (mid == 2) ? L_JC : L_NONE;
      else if (op == 2)  v = L_IN;
      else if (op == 4)  v = L_OUT;
      else if (op == 7)  v = L_NOP;
      else if (op == 8)  v = L_HALT;
      dec_tab[b] = v;
    end

    vecs[0]  = '{8'h94, L_ADD};  vecs[1]  = '{8'hC4, L_MOVA};
    vecs[2]  = '{8'hCD, L_MOVB}; vecs[3]  = '{8'hC7, L_MOVC};
    vecs[4]  = '{8'hCF, L_MOVB}; vecs[5]  = '{8'h30, L_JMP};
    vecs[6]  = '{8'h35, L_JZ};   vecs[7]  = '{8'h3B, L_JC};
    vecs[8]  = '{8'h3C, L_NONE}; vecs[9]  = '{8'hA0, L_RSR};
    vecs[10] = '{8'hA3, L_RSL};  vecs[11] = '{8'hA1, L_NONE};
    vecs[12] = '{8'hA2, L_NONE}; vecs[13] = '{8'h6F, L_SUB};
    vecs[14] = '{8'hB3, L_AND};  vecs[15] = '{8'h50, L_NOT};
    vecs[16] = '{8'h21, L_IN};   vecs[17] = '{8'h4E, L_OUT};
    vecs[18] = '{8'h70, L_NOP};  vecs[19] = '{8'h80, L_HALT};
    vecs[20] = '{8'h00, L_NONE}; vecs[21] = '{8'h1F, L_NONE};
    vecs[22] = '{8'hD3, L_NONE}; vecs[23] = '{8'hEC, L_NONE};
    vecs[24] = '{8'hFF, L_NONE};

    rst = 1'b1; ram_dout = 8'h00; ir_ld = 0; sm_en = 0;
    cf_en = 0; zf_en = 0; c_in = 0; z_in = 0;
    model_reset();
    #3;
    chk("reset.ir", {8'h00, ir}, 16'h0000);
    chk("reset.sm_c_z", {13'h0, sm, c, z}, 16'h0000);
    chk("reset.lines", lines, L_NONE);
    #9;
    rst = 1'b0;

    // ADD with simultaneous flag write on the execute edge
    step(8'h94, 1, 1, 0, 0, 0, 0);
    chk("add.ir", {8'h00, ir}, 16'h0094);
    chk("add.sm", {15'h0, sm}, 16'h0001);
    chk("add.line", lines, L_ADD);
    chk("add.flags_not_yet", {14'h0, c, z}, 16'h0000);
    step(8'h00, 0, 1, 1, 1, 1, 0);
    chk("add.c", {15'h0, c}, 16'h0001);
    chk("add.z", {15'h0, z}, 16'h0000);
    chk("add.sm_back", {15'h0, sm}, 16'h0000);
    chk("add.line_off", lines, L_NONE);
    step(8'h00, 0, 0, 0, 1, 0, 1);
    chk("zflag.set", {14'h0, c, z}, 16'h0003);

    // Enables low hold the flags whatever the data inputs do
    for (int i = 0; i < 4; i++) begin
      step(8'h00, 0, 0, 0, 0, i[0], ~i[0]);
      chk($sformatf("hold.%0d", i), {14'h0, c, z}, 16'h0003);
    end

    // Async reset mid-execute of ADD, with flag writes pending
    step(8'h94, 1, 1, 0, 0, 0, 0);
    chk("rstmid.pre_line", lines, L_ADD);
    ram_dout = 8'h00; ir_ld = 0; sm_en = 1; cf_en = 1; zf_en = 1; c_in = 1; z_in = 1;
    #2 rst = 1'b1;
    #1;
    chk("rstmid.ir", {8'h00, ir}, 16'h0000);
    chk("rstmid.sm_c_z", {13'h0, sm, c, z}, 16'h0000);
    chk("rstmid.lines", lines, L_NONE);
    @(posedge clk);
    #1;
    chk("rstmid.no_flag_update", {14'h0, c, z}, 16'h0000);
    rst = 1'b0;
    model_reset();

    // Decode table: fetch the byte, check the execute-cycle line, return to fetch
    foreach (vecs[i]) begin
      step(vecs[i].instr, 1, 1, 0, 0, 0, 0);
      chk($sformatf("dec.%02h", vecs[i].instr), lines, vecs[i].exp_lines);
      step(8'hFF, 0, 1, 0, 0, 0, 0);
      chk($sformatf("dec.%02h.fetch_gated", vecs[i].instr), lines, L_NONE);
    end

    // Halt holds sm, ir and the halt line while the bus keeps changing
    step(8'h80, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(8'($urandom), 0, 0, 0, 0, 0, 0);
      chk($sformatf("halt.%0d", i), {ir, 6'h0, sm, halt}, 16'h8003);
    end
    rst = 1'b1;
    #1;
    chk("halt.reset", {ir, 6'h0, sm, halt}, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Random control traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      step(8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk_all($sformatf("rand.%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_seq.md
# instr_seq

Instruction register, opcode decoder, fetch/execute state bit and flag registers for the model computer. It sits between the RAM data bus and the control-signal generator. It supplies `ir`, `sm`, the one-hot instruction lines and the `z`/`c` flags. It consumes the generator's `ir_ld`, `sm_en`, `cf_en` and `zf_en` outputs.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ram_dout`  in  8  RAM data bus; carries the instruction byte during fetch.
- `ir_ld`  in  1  load `ir` from `ram_dout` at this edge.
- `sm_en`  in  1  advance `sm` at this edge.
- `cf_en`, `zf_en`  in  1 each  write enables for `c` and `z`.
- `c_in`, `z_in`  in  1 each  carry and zero results from the ALU/shifter.
- `ir`  out  8  instruction register.
- `sm`  out  1  state bit: 0 = fetch, 1 = execute.
- `c`, `z`  out  1 each  registered carry and zero flags.
- `mova`, `movb`, `movc`, `add`, `sub`, `and1`, `not1`, `rsr`, `rsl`, `jmp`, `jz`, `jc`, `in1`, `out1`, `nop`, `halt`  out  1 each  decoded instruction lines, at most one high.

## Operation
- **Registers:** `ir`, `sm`, `c` and `z` are the only state; every other output is combinational.
- **`ir` load:** `ir <= ram_dout` when `ir_ld` = 1; otherwise `ir` holds.
- **State bit:** `sm <= ~sm` when `sm_en` = 1; otherwise `sm` holds.
- **Carry flag:** `c <= c_in` when `cf_en` = 1; otherwise `c` holds.
- **Zero flag:** `z <= z_in` when `zf_en` = 1; otherwise `z` holds.
- **Gating:** every decode line is forced to 0 while `sm` = 0. While `sm` = 1, the line is decoded from `ir` as follows.
- **Opcode `ir[7:4]` = 1100 (moves):**
  - `ir[3:2]` = 11 → `movb` (store); this includes 8'hCF.
  - else `ir[1:0]` = 11 → `movc` (load).
  - else → `mova`.
- **Opcode 1001:** `add`.
- **Opcode 0110:** `sub`.
- **Opcode 1011:** `and1`.
- **Opcode 0101:** `not1`.
- **Opcode 1010 (shifts), selected by `ir[1:0]`:**
  - 00 → `rsr`.
  - 11 → `rsl`.
  - 01 or 10 → no line asserted.
- **Opcode 0011 (jumps), selected by `ir[3:2]`; `ir[1:0]` is ignored:**
  - 00 → `jmp`.
  - 01 → `jz`.
  - 10 → `jc`.
  - 11 → no line asserted.
- **Opcode 0010:** `in1`.
- **Opcode 0100:** `out1`.
- **Opcode 0111:** `nop`.
- **Opcode 1000:** `halt`.
- **Undefined opcodes** (0000, 0001, 1101, 1110, 1111): all lines stay 0. The execute cycle still completes and `sm` returns to 0.
- **Halt:** the generator drives `sm_en` = 0 during a `halt` execute cycle. `sm` then stays 1, `ir` is not reloaded and `halt` stays high until `rst`.

## Timing
- **Reset:** `rst` high clears `ir` = 8'h00, `sm` = 0, `c` = 0 and `z` = 0 immediately, without waiting for `clk`.
  - Consequence: every decode line is 0 while `rst` is high.
  - Reset asserted mid-execute aborts the instruction; no flag update occurs on that edge.
- **Instruction length:** every instruction takes 2 cycles, fetch (`sm` = 0) then execute (`sm` = 1).
- **Fetch cycle:** `ir` is captured on the rising edge that ends the fetch cycle. The decode lines become valid combinationally in the following execute cycle.
- **Flag writes:** flags are written on the edge that ends an execute cycle. The new value is visible to `jz`/`jc` from the next instruction onward, never within the same instruction.
- **Simultaneous `cf_en` and `zf_en`:** both flags update on the same edge.
- **Enable precedence:** an enable low always holds the register, regardless of its data input.

## Test plan
- **Reset:** apply `rst` mid-execute with `ir` = 8'h94 → `ir` = 00, `sm` = 0, `c` = `z` = 0 and all decode lines 0 before the next edge.
- **ADD with flag write:** `ram_dout` = 8'h94, `ir_ld` = 1, `sm_en` = 1 → after the edge `ir` = 94, `sm` = 1, `add` = 1. Then `cf_en` = `zf_en` = 1, `c_in` = 1, `z_in` = 0 → after the next edge `c` = 1, `z` = 0, `sm` = 0, `add` = 0.
- **Move decode:** 8'hC4 → `mova`; 8'hCD → `movb`; 8'hC7 → `movc`; 8'hCF → `movb` only.
- **Jump and shift decode:** 8'h30 → `jmp`; 8'h35 → `jz`; 8'h3B → `jc`; 8'h3C → none; 8'hA0 → `rsr`; 8'hA3 → `rsl`; 8'hA1 → none.
- **Flag hold:** with `cf_en` = `zf_en` = 0, toggle `c_in`/`z_in` over 4 cycles → `c` and `z` remain unchanged.
- **Halt:** load 8'h80, then `sm_en` = 0 → `halt` = 1, `sm` = 1 and `ir` = 80 held for 10 cycles while `ram_dout` changes. Then `rst` → `sm` = 0 and `halt` = 0.
